// File: rtl/axis_seq_pkg.sv
// Shared definitions for the AXI-Stream command sequencer: opcodes,
// header field positions and the sequencer state encoding.
package axis_seq_pkg;

    localparam logic [7:0] OP_CLEAR = 8'h00;
    localparam logic [7:0] OP_LOAD  = 8'h01;
    localparam logic [7:0] OP_RUN   = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;

    // Header layout: [63:56] opcode, [55:48] dest, [31:16] base, [15:0] len
    localparam int OPC_LSB  = 56;
    localparam int DEST_LSB = 48;
    localparam int BASE_LSB = 16;
    localparam int LEN_LSB  = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_WAIT_DONE,
        S_READ,
        S_DRAIN
    } seq_state_t;

endpackage

// File: rtl/seq_skid_buf.sv
// Two-entry readback buffer (data + last) between the memory read port and
// the S2MM FIFO; reports free slots so the read issuer never overruns it.
module seq_skid_buf (
    input  logic        aclk,
    input  logic        areset,
    input  logic        in_valid,
    input  logic [64:0] in_data,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [64:0] out_data,
    output logic [1:0]  free_slots
);

    logic [64:0] ent_q [2];
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [1:0]  cnt_q;
    logic        pop;

    assign out_valid  = (cnt_q != 2'd0);
    assign out_data   = ent_q[rd_ptr_q];
    assign pop        = out_valid & out_ready;
    // A slot being popped this cycle counts as free, which keeps 1 word/cycle
    assign free_slots = 2'd2 - cnt_q + {1'b0, pop};

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (in_valid) begin
                ent_q[wr_ptr_q] <= in_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop)
                rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, in_valid} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/axis_cmd_sequencer.sv
// Command sequencer: pops headers/payload from MM2S, loads memories, runs the
// engine, reads memories back to S2MM. Define SEQ_TIMEOUT_EN for a done watchdog.
module axis_cmd_sequencer
    import axis_seq_pkg::*;
#(
    parameter int N_DEST         = 4,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [63:0]               mm2s_data,
    input  logic                      mm2s_valid,
    output logic                      mm2s_ready,
    output logic [63:0]               s2mm_data,
    output logic                      s2mm_valid,
    input  logic                      s2mm_ready,
    output logic                      s2mm_last,
    output logic [N_DEST-1:0]         mem_wr_sel,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [63:0]               mem_wr_data,
    output logic                      mem_rd_en,
    output logic [$clog2(N_DEST)-1:0] mem_rd_sel,
    input  logic [63:0]               mem_rd_data,
    output logic                      start,
    input  logic                      done,
    output logic                      busy,
    output logic                      err
);

    localparam int         SEL_W    = $clog2(N_DEST);
    localparam logic [7:0] N_DEST_B = 8'(N_DEST);

    seq_state_t  state_q, state_d;
    logic [7:0]  hdr_opc, hdr_dest;
    logic [15:0] hdr_base, hdr_len;
    logic        hdr_dest_ok;
    logic        unused_hdr;

    logic [15:0]       rem_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [SEL_W-1:0]  dest_q;
    logic              dest_ok_q;
    logic              rd_inflight_q, rd_last_q;
    logic [1:0]        free_slots;
    logic [64:0]       skid_out;
    logic              ready_i, hdr_hs, ld_hs, rd_issue, tmo;

    assign hdr_opc     = mm2s_data[OPC_LSB  +: 8];
    assign hdr_dest    = mm2s_data[DEST_LSB +: 8];
    assign hdr_base    = mm2s_data[BASE_LSB +: 16];
    assign hdr_len     = mm2s_data[LEN_LSB  +: 16];
    assign hdr_dest_ok = (hdr_dest < N_DEST_B);
    assign unused_hdr  = ^mm2s_data[47:32];

`ifdef SEQ_TIMEOUT_EN
    logic [31:0] to_cnt_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            to_cnt_q <= '0;
        else if (state_q == S_WAIT_DONE)
            to_cnt_q <= to_cnt_q + 32'd1;
        else
            to_cnt_q <= '0;
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        ready_i  = 1'b0;
        start    = 1'b0;
        rd_issue = 1'b0;
        hdr_hs   = 1'b0;
        ld_hs    = 1'b0;
        tmo      = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_i = 1'b1;
                if (mm2s_valid) begin
                    hdr_hs = 1'b1;
                    case (hdr_opc)
                        OP_LOAD: state_d = S_LOAD;
                        OP_RUN:  state_d = S_RUN;
                        OP_READ: state_d = hdr_dest_ok ? S_READ : S_IDLE;
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_LOAD: begin
                // Ready is withheld once len words are taken so len=0 pops nothing
                ready_i = (rem_q != 16'd0);
                ld_hs   = ready_i & mm2s_valid;
                if (rem_q == 16'd0 || (ld_hs && rem_q == 16'd1))
                    state_d = S_IDLE;
            end
            S_RUN: begin
                start   = 1'b1;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (done)
                    state_d = S_IDLE;
`ifdef SEQ_TIMEOUT_EN
                else if (to_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    tmo     = 1'b1;
                    state_d = S_IDLE;
                end
`endif
            end
            S_READ: begin
                // Leave room for the read already in flight
                rd_issue = (rem_q != 16'd0) && (free_slots > {1'b0, rd_inflight_q});
                if (rem_q == 16'd0)
                    state_d = S_IDLE;
                else if (rd_issue && rem_q == 16'd1)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!rd_inflight_q && !s2mm_valid)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mm2s_ready = ready_i & ~areset;
    assign mem_rd_en  = rd_issue;
    assign busy       = (state_q != S_IDLE);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            mem_wr_sel    <= '0;
            mem_addr      <= '0;
            mem_wr_data   <= '0;
            mem_rd_sel    <= '0;
            err           <= 1'b0;
            rem_q         <= '0;
            ptr_q         <= '0;
            dest_q        <= '0;
            dest_ok_q     <= 1'b0;
            rd_inflight_q <= 1'b0;
            rd_last_q     <= 1'b0;
        end else begin
            mem_wr_sel    <= '0;
            rd_inflight_q <= rd_issue;
            if (rd_issue) begin
                rd_last_q <= (rem_q == 16'd1);
                rem_q     <= rem_q - 16'd1;
                mem_addr  <= mem_addr + ADDR_W'(1);
            end
            if (ld_hs) begin
                mem_wr_sel  <= dest_ok_q ? (N_DEST'(1) << dest_q) : '0;
                mem_addr    <= ptr_q;
                mem_wr_data <= mm2s_data;
                ptr_q       <= ptr_q + ADDR_W'(1);
                rem_q       <= rem_q - 16'd1;
            end
            if (hdr_hs) begin
                rem_q     <= hdr_len;
                ptr_q     <= ADDR_W'(hdr_base);
                dest_q    <= hdr_dest[SEL_W-1:0];
                dest_ok_q <= hdr_dest_ok;
                case (hdr_opc)
                    OP_CLEAR: err <= 1'b0;
                    OP_LOAD:  if (!hdr_dest_ok) err <= 1'b1;
                    OP_RUN:   ;
                    OP_READ: begin
                        if (!hdr_dest_ok) begin
                            err <= 1'b1;
                        end else begin
                            mem_addr   <= ADDR_W'(hdr_base);
                            mem_rd_sel <= hdr_dest[SEL_W-1:0];
                        end
                    end
                    default:  err <= 1'b1;
                endcase
            end
            if (tmo)
                err <= 1'b1;
        end
    end

    seq_skid_buf u_skid (
        .aclk       (aclk),
        .areset     (areset),
        .in_valid   (rd_inflight_q),
        .in_data    ({rd_last_q, mem_rd_data}),
        .out_ready  (s2mm_ready),
        .out_valid  (s2mm_valid),
        .out_data   (skid_out),
        .free_slots (free_slots)
    );

    assign s2mm_data = skid_out[63:0];
    assign s2mm_last = skid_out[64] & s2mm_valid;

endmodule

// File: tb/tb_axis_cmd_sequencer.sv
// Directed bench for axis_cmd_sequencer: load, wrap, readback with
// backpressure, run/done, error paths, len=0, async reset mid-read.
module tb_axis_cmd_sequencer;
    import axis_seq_pkg::*;

`ifdef SEQ_TIMEOUT_EN
    localparam int DONE_DLY = 5;
`else
    localparam int DONE_DLY = 10;
`endif

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [63:0] mm2s_data = '0;
    logic        mm2s_valid = 1'b0;
    logic        mm2s_ready;
    logic [63:0] s2mm_data;
    logic        s2mm_valid;
    logic        s2mm_ready = 1'b0;
    logic        s2mm_last;
    logic [3:0]  mem_wr_sel;
    logic [15:0] mem_addr;
    logic [63:0] mem_wr_data;
    logic        mem_rd_en;
    logic [1:0]  mem_rd_sel;
    logic [63:0] mem_rd_data = '0;
    logic        start;
    logic        done = 1'b0;
    logic        busy;
    logic        err;

    always #5 aclk = ~aclk;

    axis_cmd_sequencer #(.N_DEST(4), .ADDR_W(16), .TIMEOUT_CYCLES(8)) dut (
        .aclk(aclk), .areset(areset),
        .mm2s_data(mm2s_data), .mm2s_valid(mm2s_valid), .mm2s_ready(mm2s_ready),
        .s2mm_data(s2mm_data), .s2mm_valid(s2mm_valid), .s2mm_ready(s2mm_ready),
        .s2mm_last(s2mm_last),
        .mem_wr_sel(mem_wr_sel), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_en(mem_rd_en), .mem_rd_sel(mem_rd_sel), .mem_rd_data(mem_rd_data),
        .start(start), .done(done), .busy(busy), .err(err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    function automatic logic [63:0] rd_model(input logic [1:0] sel, input logic [15:0] a);
        return {8'h00, 6'd0, sel, 8'hA5, 24'h0, a};
    endfunction

    function automatic logic [63:0] hdr(input logic [7:0] op, input logic [7:0] dest,
                                        input logic [15:0] base, input logic [15:0] len);
        return {op, dest, 16'h0, base, len};
    endfunction

    // memory returns data the cycle after the read strobe
    always @(posedge aclk) if (mem_rd_en) mem_rd_data <= rd_model(mem_rd_sel, mem_addr);

    logic [3:0]  wq_sel[$];
    logic [15:0] wq_addr[$];
    logic [63:0] wq_data[$];
    int          wq_cyc[$];
    logic [63:0] rq_data[$];
    logic        rq_last[$];
    int          stall_bad = 0;
    int          start_cnt = 0;
    logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [63:0] pd = '0;

    always @(negedge aclk) begin
        if (mem_wr_sel != 4'd0) begin
            wq_sel.push_back(mem_wr_sel);
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_wr_data);
            wq_cyc.push_back(cyc);
        end
        if (start) start_cnt++;
        if (!areset && pv && !pr && (!s2mm_valid || s2mm_data != pd || s2mm_last != pl))
            stall_bad++;
        if (s2mm_valid && s2mm_ready) begin
            rq_data.push_back(s2mm_data);
            rq_last.push_back(s2mm_last);
        end
        pv = s2mm_valid & ~areset;
        pr = s2mm_ready;
        pd = s2mm_data;
        pl = s2mm_last;
    end

    logic [3:0] pat = 4'b1001;
    int         pidx = 0;
    logic       pat_en = 1'b0;

    always @(posedge aclk) begin
        #1;
        if (pat_en) begin
            s2mm_ready = pat[pidx];
            pidx = (pidx + 1) % 4;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    // call aligned just after a rising edge; returns just after the handshake edge
    task automatic send(input logic [63:0] w);
        int t = 0;
        mm2s_data  = w;
        mm2s_valid = 1'b1;
        @(negedge aclk);
        while (!mm2s_ready && t < 100) begin
            @(negedge aclk);
            t++;
        end
        if (t >= 100) chk("send_timeout", 64'(t), 64'd0);
        @(posedge aclk);
        #1;
        mm2s_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (busy && t < 300) begin
            tick(1);
            t++;
        end
        chk(tag, 64'(busy), 64'd0);
    endtask

    task automatic clr_q();
        wq_sel.delete(); wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
        rq_data.delete(); rq_last.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          c0;
        int          ready_bad;
        logic [15:0] exp_a [3];
        logic [4:0]  lv;

        tick(2);
        @(negedge aclk);
        chk("rst_ctl", 64'({mm2s_ready, busy, err, start, mem_rd_en, s2mm_valid, s2mm_last}), 64'd0);
        chk("rst_s2mm_data", s2mm_data, 64'd0);
        chk("rst_mem", 64'({mem_wr_sel, mem_addr, mem_rd_sel}), 64'd0);
        chk("rst_wdata", mem_wr_data, 64'd0);
        @(posedge aclk); #1;
        areset = 1'b0;
        tick(1);
        @(negedge aclk);
        chk("idle_ready", 64'({busy, mm2s_ready}), 64'b01);
        tick(1);

        // LOAD dest=1 base=0x10 len=4, back-to-back payload
        clr_q();
        send(hdr(OP_LOAD, 8'd1, 16'h0010, 16'd4));
        send(64'hA);
        c0 = cyc;
        send(64'hB);
        send(64'hC);
        send(64'hD);
        tick(3);
        chk("ld_cnt", 64'(wq_sel.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < wq_sel.size())
                chk($sformatf("ld_w%0d", i), 64'({wq_sel[i], wq_addr[i], wq_data[i]}),
                    64'({4'b0010, 16'h0010 + 16'(i), 64'hA + 64'(i)}));
        if (wq_cyc.size() == 4) begin
            chk("ld_latency", 64'(wq_cyc[0]), 64'(c0));
            chk("ld_b2b", 64'(wq_cyc[3] - wq_cyc[0]), 64'd3);
        end
        chk("ld_busy_fall", 64'(busy), 64'd0);

        // LOAD across the address wrap
        clr_q();
        exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000};
        send(hdr(OP_LOAD, 8'd0, 16'hFFFE, 16'd3));
        send(64'h1); send(64'h2); send(64'h3);
        tick(3);
        chk("wrap_cnt", 64'(wq_sel.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            if (i < wq_sel.size())
                chk($sformatf("wrap_w%0d", i), 64'({wq_sel[i], wq_addr[i], wq_data[i][15:0]}),
                    64'({4'b0001, exp_a[i], 16'(i + 1)}));

        // READ dest=2 len=5 with ready pattern 1,0,0,1
        clr_q();
        stall_bad = 0;
        pidx = 0;
        pat_en = 1'b1;
        send(hdr(OP_READ, 8'd2, 16'h0040, 16'd5));
        @(negedge aclk); chk("rd_k1", 64'({busy, mem_rd_en}), 64'b11);
        @(negedge aclk); chk("rd_k2_valid", 64'(s2mm_valid), 64'd0);
        @(negedge aclk); chk("rd_k3_valid", 64'(s2mm_valid), 64'd1);
        tick(1);
        wait_idle("rd_idle");
        tick(6);
        pat_en = 1'b0;
        s2mm_ready = 1'b0;
        chk("rd_cnt", 64'(rq_data.size()), 64'd5);
        lv = '0;
        for (int i = 0; i < 5; i++)
            if (i < rq_data.size()) begin
                chk($sformatf("rd_w%0d", i), rq_data[i], rd_model(2'd2, 16'h0040 + 16'(i)));
                lv[i] = rq_last[i];
            end
        chk("rd_last", 64'(lv), 64'b10000);
        chk("rd_stall_stable", 64'(stall_bad), 64'd0);

        // RUN with done DONE_DLY cycles after start
        start_cnt = 0;
        ready_bad = 0;
        send(hdr(OP_RUN, 8'd0, 16'h0, 16'h0));
        @(negedge aclk); chk("run_start", 64'(start), 64'd1);
        repeat (DONE_DLY - 1) begin
            @(negedge aclk);
            if (mm2s_ready) ready_bad++;
        end
        @(posedge aclk); #1; done = 1'b1;
        @(negedge aclk); if (mm2s_ready) ready_bad++;
        @(posedge aclk); #1; done = 1'b0;
        @(negedge aclk);
        chk("run_idle", 64'({busy, mm2s_ready}), 64'b01);
        chk("run_hold_ready", 64'(ready_bad), 64'd0);
        chk("run_one_start", 64'(start_cnt), 64'd1);
        tick(1);
        send(hdr(OP_CLEAR, 8'd0, 16'h0, 16'h0));
        tick(1);

        // bad opcode, LOAD to bad dest, CLEAR, then an aligned LOAD
        send(hdr(8'h7F, 8'd0, 16'h0, 16'd3));
        @(negedge aclk); chk("bad_op", 64'({err, busy, mm2s_ready}), 64'b101);
        tick(1);
        clr_q();
        send(hdr(OP_LOAD, 8'd5, 16'h0020, 16'd2));
        send(64'h11); send(64'h22);
        tick(2);
        chk("bad_dest_nowr", 64'(wq_sel.size()), 64'd0);
        chk("bad_dest_err", 64'({err, busy}), 64'b10);
        send(hdr(OP_CLEAR, 8'd0, 16'h0, 16'h0));
        @(negedge aclk); chk("clear", 64'(err), 64'd0);
        tick(1);
        send(hdr(OP_LOAD, 8'd3, 16'h0100, 16'd1));
        send(64'h33);
        tick(2);
        chk("align_cnt", 64'(wq_sel.size()), 64'd1);
        if (wq_sel.size() == 1)
            chk("align_w", 64'({wq_sel[0], wq_addr[0], wq_data[0][15:0]}), 64'({4'b1000, 16'h0100, 16'h0033}));

        // READ to bad dest emits nothing
        clr_q();
        s2mm_ready = 1'b1;
        send(hdr(OP_READ, 8'd9, 16'h0, 16'd3));
        @(negedge aclk); chk("rd_bad", 64'({err, busy, mem_rd_en}), 64'b100);
        tick(5);
        chk("rd_bad_none", 64'(rq_data.size()), 64'd0);
        send(hdr(OP_CLEAR, 8'd0, 16'h0, 16'h0));
        tick(1);

        // len=0 for READ and LOAD
        send(hdr(OP_READ, 8'd1, 16'h0010, 16'd0));
        tick(4);
        chk("rd_len0", 64'({rq_data.size(), busy}), 64'd0);
        send(hdr(OP_LOAD, 8'd1, 16'h0050, 16'd0));
        tick(2);
        chk("ld_len0_idle", 64'(busy), 64'd0);
        send(hdr(OP_LOAD, 8'd2, 16'h0060, 16'd1));
        send(64'h77);
        tick(2);
        chk("ld_len0_cnt", 64'(wq_sel.size()), 64'd1);
        if (wq_sel.size() == 1)
            chk("ld_len0_next", 64'({wq_sel[0], wq_addr[0], wq_data[0][15:0]}), 64'({4'b0100, 16'h0060, 16'h0077}));
        chk("len0_err", 64'(err), 64'd0);

`ifdef SEQ_TIMEOUT_EN
        send(hdr(OP_RUN, 8'd0, 16'h0, 16'h0));
        repeat (9) @(negedge aclk);
        chk("tmo_pre", 64'(err), 64'd0);
        @(negedge aclk);
        chk("tmo_err", 64'({err, busy}), 64'b10);
        tick(1);
        send(hdr(OP_CLEAR, 8'd0, 16'h0, 16'h0));
        tick(1);
`endif

        // async reset while a stalled READ holds data
        s2mm_ready = 1'b0;
        send(hdr(OP_READ, 8'd1, 16'h0000, 16'd5));
        tick(3);
        chk("pre_arst_busy", 64'({busy, s2mm_valid}), 64'b11);
        areset = 1'b1;
        #1;
        chk("arst_ctl", 64'({mm2s_ready, busy, err, start, mem_rd_en, s2mm_valid, s2mm_last}), 64'd0);
        chk("arst_s2mm_data", s2mm_data, 64'd0);
        chk("arst_mem", 64'({mem_wr_sel, mem_addr, mem_rd_sel}), 64'd0);
        chk("arst_wdata", mem_wr_data, 64'd0);
        tick(1);
        areset = 1'b0;
        tick(1);
        @(negedge aclk);
        chk("post_arst", 64'({busy, mm2s_ready, s2mm_valid}), 64'b010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
